wb_rr_arbiter: RTL

- Two-master, one-slave Wishbone classic arbiter sharing the single memory slave between the D$/LSU port (master 0) and the I$ port (master 1).
- Round-robin grant, held for the full cyc_i cycle of the granted master.
- Applies a fixed base-address offset toward the slave.
- Watchdog returns err to a master whose slave never acks.

---
 rtl/wb_rr_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant held for a whole cycle,
// a fixed slave-side address offset, and a stall watchdog that answers err.
module wb_rr_arbiter #(
  parameter int unsigned         ADDR_W      = 32,
  parameter int unsigned         DATA_W      = 32,
  parameter int unsigned         SEL_W       = 4,
  parameter logic [ADDR_W-1:0]   ADDR_OFFSET = 'h80000000,
  parameter int unsigned         TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic              m0_we_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic              m1_we_i,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  output logic [SEL_W-1:0]  s_sel_o,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        grant_o
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state, state_next;
  logic             last_owner, last_owner_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             err0_q, err1_q, err0_next, err1_next;
  logic             own0, own1, waiting;

  assign own0    = (state == OWN0);
  assign own1    = (state == OWN1);
  assign grant_o = {own1, own0};

  // A waiting cycle: the owner strobes and the slave has not acked.
  assign waiting = ((own0 & m0_stb_i) | (own1 & m1_stb_i)) & ~s_ack_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      cnt        <= '0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      state      <= state_next;
      last_owner <= last_owner_next;
      cnt        <= cnt_next;
      err0_q     <= err0_next;
      err1_q     <= err1_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_owner_next = last_owner;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_next = last_owner ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_next = OWN0;
        else if (m1_cyc_i)        state_next = OWN1;
      end
      OWN0: begin
        if (!m0_cyc_i || err0_q) begin
          state_next      = IDLE;
          last_owner_next = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc_i || err1_q) begin
          state_next      = IDLE;
          last_owner_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The err flop is set at the edge where the count reaches TIMEOUT; the owner is
  // released one cycle later, so the pulse is seen while the slave is still selected.
  always_comb begin
    cnt_next  = '0;
    err0_next = 1'b0;
    err1_next = 1'b0;
    if (waiting && !err0_q && !err1_q) begin
      cnt_next = cnt + CNT_W'(1);
      if (cnt == CNT_LAST) begin
        err0_next = own0;
        err1_next = own1;
      end
    end
  end

  assign m0_err_o = err0_q;
  assign m1_err_o = err1_q;

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (own0) begin
      s_adr_o = m0_adr_i - ADDR_OFFSET;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
    end else if (own1) begin
      s_adr_o = m1_adr_i - ADDR_OFFSET;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
    end
  end

  assign m0_ack_o = s_ack_i & own0 & m0_stb_i;
  assign m1_ack_o = s_ack_i & own1 & m1_stb_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule
